led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_pattern_gen_if.sv | 16 +
 rtl/led_pattern_gen_debounce.sv | 49 ++++
 rtl/led_pattern_gen.sv | 127 ++++++++++++
 tb/tb_led_pattern_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared encodings for the LED pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

    // Pattern modes as seen on the MODE pins.
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_ROT    = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    // Travel direction of the lit bit in bounce mode.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: board-side bundle of switch/button inputs and LED/tick outputs.
// Latency: n/a (wires only).
// Backpressure: none; master drives SW/MODE/BTNC, slave drives LED/TICK.
interface led_pattern_gen_if #(
    parameter int N_LED = 8,
    parameter int N_SW  = 4
);
    logic [N_SW-1:0]  SW;
    logic [1:0]       MODE;
    logic             BTNC;
    logic [N_LED-1:0] LED;
    logic             TICK;

    modport master (output SW, MODE, BTNC, input  LED, TICK);
    modport slave  (input  SW, MODE, BTNC, output LED, TICK);
endinterface

// File: rtl/led_pattern_gen_debounce.sv
// btn_debounce: accepts a new button level after DEB_CYCLES consecutive differing samples.
// Latency: level/rise update on the DEB_CYCLES-th stable sample; rise is a registered 1-cycle pulse.
// Backpressure: none; shorter pulses are dropped.
// Ports: clk, rst_n (async, active-low), raw (already synchronised), level, rise.
module btn_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    if (DEB_CYCLES < 1) begin : g_param_check
        $error("btn_debounce: DEB_CYCLES must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          accept;

    // cnt_q holds how many samples in a row have disagreed with level_q;
    // the last one of a full run is the sample that gets accepted.
    assign accept = (raw != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= accept && raw;
            if (raw == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                level_q <= raw;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: mirrors switches onto LED[N_SW-1:0] and steps a pattern on LED[N_LED-1:N_SW].
// Latency: SW -> LED 3 cycles; MODE change -> pattern reload 3 cycles; pattern steps the cycle after TICK.
// Backpressure: none; BTNC toggles run/pause of the pattern, switch mirroring never stalls.
// Ports: CLK100MHZ, CPU_RESETN (async, active-low), io (slave): SW/MODE/BTNC in, LED/TICK out.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int              N_LED      = 8,
    parameter int              N_SW       = 4,
    parameter int              TICK_DIV   = 1000000,
    parameter int              DEB_CYCLES = 65536,
    parameter logic [N_SW-1:0] INV_MASK   = '0
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    led_pattern_gen_if.slave io
);
    localparam int P  = N_LED - N_SW;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

    if (P < 2 || TICK_DIV < 2) begin : g_param_check
        $error("led_pattern_gen: need N_LED-N_SW >= 2 and TICK_DIV >= 2");
    end

    logic [N_SW-1:0] sw_s1, sw_s2, led_lo;
    logic [1:0]      mode_s1, mode_s2;
    mode_t           mode_q;
    logic            btn_s1, btn_s2;
    logic            btn_lvl, btn_rise;
    logic            run_q;
    logic [CW-1:0]   presc_q, presc_d;
    logic [P-1:0]    pat_q, pat_d;
    dir_t            dir_q, dir_d;
    logic            mode_chg, step;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .raw   (btn_s2),
        .level (btn_lvl),
        .rise  (btn_rise)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            led_lo  <= '0;
            mode_s1 <= '0;
            mode_s2 <= '0;
            mode_q  <= MODE_UP;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            run_q   <= 1'b1;
            presc_q <= '0;
            pat_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            sw_s1   <= io.SW;
            sw_s2   <= sw_s1;
            led_lo  <= sw_s2 ^ INV_MASK;
            mode_s1 <= io.MODE;
            mode_s2 <= mode_s1;
            mode_q  <= mode_t'(mode_s2);
            btn_s1  <= io.BTNC;
            btn_s2  <= btn_s1;
            // Rise and the new high level land in the same cycle; requiring
            // both keeps run from toggling on anything but a real press.
            if (btn_rise && btn_lvl) begin
                run_q <= ~run_q;
            end
            presc_q <= presc_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        presc_d  = presc_q;
        pat_d    = pat_q;
        dir_d    = dir_q;
        mode_chg = (mode_s2 != mode_q);
        step     = run_q && (presc_q == PRESC_MAX);

        if (mode_chg) begin
            // Reload is independent of run and overrides a step due this cycle.
            presc_d = '0;
            dir_d   = DIR_LEFT;
            case (mode_t'(mode_s2))
                MODE_UP:   pat_d = '0;
                MODE_DOWN: pat_d = '1;
                default:   pat_d = P'(1);
            endcase
        end else if (run_q) begin
            presc_d = step ? '0 : presc_q + CW'(1);
            if (step) begin
                unique case (mode_q)
                    MODE_UP:   pat_d = pat_q + P'(1);
                    MODE_DOWN: pat_d = pat_q - P'(1);
                    MODE_ROT:  pat_d = {pat_q[P-2:0], pat_q[P-1]};
                    MODE_BOUNCE: begin
                        // Turn around at either end by stepping back one position.
                        if (dir_q == DIR_LEFT) begin
                            if (pat_q[P-1]) begin
                                pat_d = pat_q >> 1;
                                dir_d = DIR_RIGHT;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d = pat_q << 1;
                                dir_d = DIR_LEFT;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign io.TICK = step && !mode_chg;
    assign io.LED  = {pat_q, led_lo};
endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
    localparam int N_LED = 8;
    localparam int N_SW  = 4;
    localparam int TD    = 4;
    localparam int DEB   = 3;
    localparam int P     = N_LED - N_SW;
    localparam int PMOD  = 1 << P;
    localparam logic [N_SW-1:0] INV = 4'b0011;

    logic CLK100MHZ  = 1'b0;
    logic CPU_RESETN = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    led_pattern_gen_if #(.N_LED(N_LED), .N_SW(N_SW)) io ();

    led_pattern_gen #(
        .N_LED      (N_LED),
        .N_SW       (N_SW),
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB),
        .INV_MASK   (INV)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .io         (io)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Reference model: pattern as an integer (one-hot modes as a bit position),
    // synchronisers as 2-deep delay lines, debounce as a window of recent samples.
    int m_pat, m_pos, m_dir_right, m_presc, m_run, m_mode_reg, m_lvl, m_rise, m_led_lo;
    int m_sw[2];
    int m_md[2];
    int m_bt[2];
    int hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_pos = 0; m_dir_right = 0; m_presc = 0; m_run = 1;
        m_mode_reg = 0; m_lvl = 0; m_rise = 0; m_led_lo = 0;
        m_sw[0] = 0; m_sw[1] = 0; m_md[0] = 0; m_md[1] = 0; m_bt[0] = 0; m_bt[1] = 0;
        hist.delete();
    endtask

    task automatic model_step();
        int mode_seen = m_md[1];
        int btn_seen  = m_bt[1];
        bit chg = (mode_seen != m_mode_reg);
        bit stp = (m_run != 0) && (m_presc == TD - 1);
        bit acc = 1'b0;

        m_led_lo = m_sw[1] ^ int'(INV);
        m_sw[1] = m_sw[0]; m_sw[0] = int'(io.SW);
        m_md[1] = m_md[0]; m_md[0] = int'(io.MODE);
        m_bt[1] = m_bt[0]; m_bt[0] = int'(io.BTNC);

        if (chg) begin
            m_mode_reg = mode_seen; m_presc = 0; m_dir_right = 0; m_pos = 0;
            case (mode_seen)
                0:       m_pat = 0;
                1:       m_pat = PMOD - 1;
                default: m_pat = 1;
            endcase
        end else if (m_run != 0) begin
            m_presc = (m_presc + 1) % TD;
            if (stp) begin
                case (m_mode_reg)
                    0: m_pat = (m_pat + 1) % PMOD;
                    1: m_pat = (m_pat + PMOD - 1) % PMOD;
                    2: begin m_pos = (m_pos + 1) % P; m_pat = 1 << m_pos; end
                    default: begin
                        if (m_dir_right == 0) begin
                            if (m_pos == P - 1) begin m_pos = P - 2; m_dir_right = 1; end
                            else m_pos = m_pos + 1;
                        end else begin
                            if (m_pos == 0) begin m_pos = 1; m_dir_right = 0; end
                            else m_pos = m_pos - 1;
                        end
                        m_pat = 1 << m_pos;
                    end
                endcase
            end
        end

        // A press seen by the debouncer toggles run one cycle after acceptance.
        m_run = m_run ^ m_rise;
        hist.push_back(btn_seen);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            acc = 1'b1;
            foreach (hist[i]) if (hist[i] == m_lvl) acc = 1'b0;
        end
        m_rise = (acc && btn_seen == 1) ? 1 : 0;
        if (acc) m_lvl = btn_seen;
    endtask

    task automatic compare();
        int exp_tick = (m_run != 0 && m_presc == TD - 1 && m_md[1] == m_mode_reg) ? 1 : 0;
        chk("led", 32'(io.LED), 32'((m_pat << N_SW) | m_led_lo));
        chk("tick", 32'(io.TICK), 32'(exp_tick));
    endtask

    task automatic cycle();
        @(posedge CLK100MHZ);
        if (CPU_RESETN) model_step();
        @(negedge CLK100MHZ);
        compare();
    endtask

    // Reset pulse in the middle of a low clock phase, one posedge inside it.
    task automatic do_reset();
        #2 CPU_RESETN = 1'b0;
        model_reset();
        #1;
        chk("rst_led_now", 32'(io.LED), 32'h0);
        chk("rst_tick_now", 32'(io.TICK), 32'h0);
        @(negedge CLK100MHZ);
        compare();
        CPU_RESETN = 1'b1;
    endtask

    // Runs until TICK, then one more cycle; gap counts cycles up to the tick
    // starting from the cycle after the previous call, so a steady period of TD shows as TD-1.
    task automatic wait_tick(output int pat, output int gap);
        gap = 0;
        do begin
            cycle();
            gap++;
        end while (!io.TICK && gap < 64);
        if (!io.TICK) chk("tick_timeout", 32'(io.TICK), 32'h1);
        cycle();
        pat = int'(io.LED[7:4]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pat, gap, frz;
        int bseq[7] = '{2, 4, 8, 4, 2, 1, 2};

        io.SW = '0; io.MODE = 2'b00; io.BTNC = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK100MHZ);
        chk("reset_led", 32'(io.LED), 32'h0);
        chk("reset_tick", 32'(io.TICK), 32'h0);
        CPU_RESETN = 1'b1;

        // Up count from reset, full wrap.
        for (int i = 1; i <= 17; i++) begin
            wait_tick(pat, gap);
            chk("up_gap", 32'(gap), 32'(TD - 1));
            chk("up_pat", 32'(pat), 32'(i % 16));
        end

        // Switch to down mid-count: reload to all-ones, prescaler restarts.
        cycle();
        io.MODE = 2'b01;
        repeat (3) cycle();
        chk("down_reload", 32'(io.LED[7:4]), 32'hF);
        for (int k = 1; k <= 16; k++) begin
            wait_tick(pat, gap);
            chk("down_gap", 32'(gap), 32'(TD - 1));
            chk("down_pat", 32'(pat), 32'((15 - k) & 15));
        end

        // Bounce.
        io.MODE = 2'b11;
        repeat (3) cycle();
        chk("bounce_reload", 32'(io.LED[7:4]), 32'h1);
        for (int k = 0; k < 7; k++) begin
            wait_tick(pat, gap);
            chk("bounce_pat", 32'(pat), 32'(bseq[k]));
        end

        // Switch mirror latency with inversion mask.
        io.SW = 4'b0101;
        repeat (2) cycle();
        chk("sw_lat2", 32'(io.LED[3:0]), 32'b0011);
        cycle();
        chk("sw_lat3", 32'(io.LED[3:0]), 32'b0110);

        // Short press ignored, long press pauses.
        io.BTNC = 1'b1; repeat (2) cycle(); io.BTNC = 1'b0;
        wait_tick(pat, gap);
        io.BTNC = 1'b1; repeat (5) cycle(); io.BTNC = 1'b0;
        repeat (3) cycle();
        frz = m_pat;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("frozen_pat", 32'(io.LED[7:4]), 32'(frz));
            chk("frozen_tick", 32'(io.TICK), 32'h0);
        end
        // Reload still happens while paused.
        io.MODE = 2'b00;
        repeat (3) cycle();
        chk("paused_reload", 32'(io.LED[7:4]), 32'h0);
        repeat (4) cycle();
        chk("paused_hold", 32'(io.LED[7:4]), 32'h0);
        io.BTNC = 1'b1; repeat (5) cycle(); io.BTNC = 1'b0;
        wait_tick(pat, gap);
        chk("resume_pat", 32'(pat), 32'h1);

        // Rotate, then reset mid-step with MODE held at rotate.
        io.MODE = 2'b10;
        repeat (3) cycle();
        chk("rot_reload", 32'(io.LED[7:4]), 32'h1);
        wait_tick(pat, gap);
        chk("rot_pat", 32'(pat), 32'h2);
        cycle();
        do_reset();
        repeat (3) cycle();
        chk("rst_rot_reload", 32'(io.LED[7:4]), 32'h1);
        wait_tick(pat, gap);
        chk("rst_first_gap", 32'(gap), 32'(TD - 1));
        chk("rst_rot_pat", 32'(pat), 32'h2);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            io.SW = 4'($urandom);
            if ($urandom_range(0, 39) == 0) io.MODE = 2'($urandom);
            if ($urandom_range(0, 5) == 0) io.BTNC = ~io.BTNC;
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
